// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the mem_responder memory slave.
//   state_e    : responder FSM states (idle / wait states / response held)
//   WAIT_CNT_W : width of the wait-state counter
//   BYTE_LANES : byte lanes per 32-bit word
package mem_rsp_pkg;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor data port (master) and the
// memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and byte-lane enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores)
//   rsp_err             : access error, only when MEM_RSP_ERR_EN is defined
interface mem_responder_if;
  import mem_rsp_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [BYTE_LANES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
`ifdef MEM_RSP_ERR_EN
  logic                  rsp_err;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
`ifdef MEM_RSP_ERR_EN
    , input rsp_err
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
`ifdef MEM_RSP_ERR_EN
    , output rsp_err
`endif
  );

endinterface

// File: rtl/mem_rsp_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// synchronous read. A read on a write cycle returns the word as it was
// before the write. Contents are not reset.
//   clk   : clock
//   en    : access strobe; read data updates only on enabled cycles
//   we    : byte-lane write enables (ignored unless en)
//   addr  : word index
//   wdata : store data
//   rdata : registered read data, held between accesses
module mem_rsp_ram
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read and lane writes share one edge; the non-blocking read sees the
  // pre-write contents.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (we[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the processor data port. Accepts one load/store
// at a time, waits WAIT_CYCLES wait states, performs the word access on the
// internal RAM and returns the response over a valid/ready handshake.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_responder_if slave modport (request and response channels)
// Parameters: DEPTH_WORDS (power of two, >= 2), WAIT_CYCLES (0..15),
// BASE_ADDR (byte address of word 0).
// Optional macro MEM_RSP_ERR_EN: adds rsp_err and flags misaligned or
// out-of-range accesses instead of aliasing them modulo DEPTH_WORDS.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  err_q, err_d;

  logic [31:0]           offset;
  logic [AW-1:0]         word_idx;
  logic                  addr_err;
  logic                  access;
  logic                  ram_en;
  logic [BYTE_LANES-1:0] ram_we;
  logic [31:0]           ram_rdata;
  logic                  req_ready;

  // Address decode on the captured request. Without the error option the
  // index simply keeps the low AW bits, so out-of-range addresses alias.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    word_idx = offset[AW+1:2];
`ifdef MEM_RSP_ERR_EN
    addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
               ((offset >> 2) >= DEPTH_WORDS);
`else
    addr_err = 1'b0;
`endif
  end

  logic unused_offset;
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

  // Gated by rst so the master never sees a ready slave while in reset.
  assign req_ready = rst && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    access      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end else begin
          access      = 1'b1;
          rsp_valid_d = 1'b1;
          err_d       = addr_err;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  // An errored access never touches the RAM.
  assign ram_en = access && !addr_err;
  assign ram_we = write_q ? be_q : '0;

  mem_rsp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (word_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // The RAM output register holds the load result; it is only exposed while
  // a load response without error is pending, giving 0 otherwise.
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (rsp_valid_q && !write_q && !err_q) ? ram_rdata : '0;
`ifdef MEM_RSP_ERR_EN
  assign bus.rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          chk;
    int unsigned exp_cyc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          outstanding = 0;
  int          rdy_mode = 1;  // 0 random, 1 high, 2 low
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  bit          prev_v = 1'b0;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: word-addressed memory with byte lanes, error rules.
  function automatic exp_t predict(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                   int unsigned acc_edge);
    exp_t        e;
    logic [31:0] off;
    int unsigned idx;
    off       = a - BASE;
    idx       = (off >> 2) % DEPTH;
    e.exp_cyc = acc_edge + 1 + W;
    e.err     = 1'b0;
    e.rdata   = 32'h0;
    e.chk     = 1'b1;
`ifdef MEM_RSP_ERR_EN
    if (a[1:0] != 2'b00 || a < BASE || (off >> 2) >= DEPTH) begin
      e.err = 1'b1;
      return e;
    end
`endif
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      end
      if (be == 4'hF) known[idx] = 1'b1;
    end else begin
      e.rdata = model[idx];
      e.chk   = known[idx];
    end
    return e;
  endfunction

  // Response ready driver, applied slightly after tb control changes.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented response against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      check32("req_ready", 32'(bus.req_ready), 32'(outstanding == 0));
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q[0];
          if (!prev_v) check32("latency", cyc, e.exp_cyc);
          if (e.chk) check32("rsp_rdata", bus.rsp_rdata, e.rdata);
`ifdef MEM_RSP_ERR_EN
          check32("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            outstanding--;
          end
        end
      end else begin
        check32("rdata_idle", bus.rsp_rdata, 32'h0);
`ifdef MEM_RSP_ERR_EN
        check32("err_idle", 32'(bus.rsp_err), 32'h0);
`endif
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit drop);
    int guard = 0;
    bit acc   = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    while (!acc) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        if (!drop) q.push_back(predict(w, a, wd, be, cyc + 1));
      end else if (++guard > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got req_ready=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (acc && !drop) outstanding++;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (outstanding != 0 || q.size() != 0) begin
      @(negedge clk);
      if (++guard > 500) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got %0d pending responses expected 0", q.size());
        q.delete();
        outstanding = 0;
      end
    end
  endtask

  task automatic wait_valid();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.rsp_valid && guard < 50);
    check32("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 32'h0;
      known[i] = 1'b0;
    end

    // Reset then idle.
    repeat (3) @(negedge clk);
    check32("req_ready_in_rst", 32'(bus.req_ready), 32'd0);
    check32("rsp_valid_in_rst", 32'(bus.rsp_valid), 32'd0);
    check32("rdata_in_rst", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check32("req_ready_after_rst", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);

    // Store then load.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wait_idle();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Byte lanes: expect DE22_BE44.
    issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Zero byte-enable store responds but leaves the word alone.
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Backpressure with an ignored second request.
    rdy_mode = 2;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'h0BAD_0BAD;
      bus.req_be    = 4'hF;
      @(negedge clk);
      check32("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rdy_mode = 1;
    wait_idle();
    repeat (4) @(negedge clk);

    // Reset during WAIT drops the store.
    issue(1'b1, 32'h20, 32'h5555_5555, 4'hF, 1'b0);
    wait_idle();
    issue(1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, 1'b1);
    rst = 1'b0;
    #1;
    check32("wait_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Reset during RESP drops rsp_valid asynchronously.
    rdy_mode = 2;
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    outstanding = 0;
    #1;
    check32("async_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check32("async_drop_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 1;
    repeat (2) @(negedge clk);

    // Address edge: 0x1000 aliases word 0 (or errors with the option).
    issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0);
    issue(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 32'h12, 32'h1234_5678, 4'hF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Random traffic: fill a window, then mixed loads/stores.
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) begin
      issue(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) a = $urandom & 32'h0000_FFFF;
      else a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    rdy_mode = 1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's data port. It accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, then performs the word access on an internal RAM and returns a response over a second valid/ready handshake. The processor core is the initiator; this block is the memory slave it talks to.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, 2: wait states between request acceptance and memory access; 0–15.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.
- `clk`  in  1  clock, all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte-lane enables for a store; bit i enables `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator takes the response.
- `rsp_rdata`  out  32  load data; 0 for stores.
- `rsp_err`  out  1  error flag; present only with `MEM_RSP_ERR_EN`.

## Operation
- The block has three states.
  - IDLE: `req_ready`=1. A request is accepted on an edge where `req_valid` && `req_ready`.
    - On acceptance, capture `write`, `addr`, `wdata`, and `be`.
    - Load wait counter = `WAIT_CYCLES`.
    - Go to WAIT.
  - WAIT: `req_ready`=0.
    - If counter ≠ 0: decrement it.
    - If counter = 0: perform the access, register `rsp_valid`=1 with `rsp_rdata`, and go to RESP.
  - RESP: `rsp_valid`=1 and `rsp_rdata` held stable.
    - On an edge with `rsp_ready`=1: clear `rsp_valid`, clear `rsp_rdata` to 0, and go to IDLE.
- Word index = (`addr` − `BASE_ADDR`) >> 2. `addr[1:0]` is ignored.
- Store: writes only the enabled lanes on the access edge. A store with `be`=4'b0000 leaves the RAM unchanged but still responds. `rsp_rdata`=0.
- Load: returns the full word as it was before this access.
- Inputs are sampled only on the acceptance edge. Changes during WAIT/RESP are ignored.
- `req_valid` asserted outside IDLE is not accepted and is not queued.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- `req_ready` is 0 while `rst` is low, and `(state==IDLE)` otherwise.
- RAM contents are not reset.
- Latency: acceptance at edge k → access performed and `rsp_valid` high after edge k+1+`WAIT_CYCLES`.
- Fastest back-to-back: next acceptance at edge k+3+`WAIT_CYCLES` (with `rsp_ready` held at 1).
- `rsp_ready` high before `rsp_valid` rises has no effect. Completion requires both signals high on the same edge.
- Reset mid-operation: the pending request is dropped. If reset lands before the access edge, no RAM write occurs. `rsp_valid` drops immediately and asynchronously.
- Address wrap (no macro): index is taken modulo `DEPTH_WORDS`, so out-of-range addresses alias.

## Configuration
- Macro: `MEM_RSP_ERR_EN`.
- Defined:
  - Adds the `rsp_err` port.
  - An access is in error if `addr[1:0]`≠0, `addr` < `BASE_ADDR`, or the word index ≥ `DEPTH_WORDS`.
  - An errored access performs no RAM write, returns `rsp_rdata`=0, and sets `rsp_err`=1 alongside `rsp_valid`. The error is cleared with the response.
  - Latency is unchanged.
- Undefined: no `rsp_err` port; wrap/alias behaviour as in Timing.

## Structure
- Package `mem_rsp_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - `WAIT_CNT_W`=4;
  - the byte-lane count constant (4).
- Sub-module `mem_rsp_ram`: a single-port `DEPTH_WORDS`×32 array with per-byte write enables and a synchronous read. It is instantiated once.
- The FSM, counter, and address decode live in `mem_responder`.

## Test plan
- Reset then idle: `rst` low then high, no requests → `req_ready`=1 from the first cycle after release; `rsp_valid`=0 throughout.
- Store/load, `WAIT_CYCLES`=2:
  - store 32'hDEAD_BEEF to 32'h10 with be=4'hF accepted at edge k → `rsp_valid` after edge k+3, `rsp_rdata`=0;
  - load 32'h10 → 32'hDEAD_BEEF.
- Byte lanes: store 32'h1122_3344 with be=4'b0101 over 32'hDEAD_BEEF → load returns 32'hDE22_BE44.
- Backpressure: `rsp_ready` held at 0 for 5 cycles → `rsp_valid` and `rsp_rdata` stable; `req_ready`=0; a second `req_valid` is ignored. Raising `rsp_ready` completes the response and `req_ready` returns high next cycle.
- Reset in WAIT:
  - store 32'hAAAA_AAAA to 32'h20 over prior 32'h5555_5555, `rst` pulsed low during WAIT → no response.
  - A later load of 32'h20 returns 32'h5555_5555.
- Address edge, `DEPTH_WORDS`=1024:
  - load 32'h1000 without macro → aliases word 0.
  - With `MEM_RSP_ERR_EN`: same load → `rsp_err`=1, `rsp_rdata`=0; store to 32'h12 → `rsp_err`=1 and the RAM is unchanged.
